// File: rtl/game_pkg.sv
// Shared definitions for the paddle/brick game controller.
//   - game_state_t : FSM state encoding (also driven out on game_state)
//   - SC_*         : PS/2 set-2 scancodes recognised by the key decoder
//   - bcd_inc_sat  : two-digit BCD increment that holds at 99
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_LOST  = 3'd4,
    ST_WON   = 3'd5,
    ST_OVER  = 3'd6
  } game_state_t;

  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_PAUSE = 8'h4D;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99)
      r = v;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'h0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// Keyboard byte bus into the game controller.
//   ps2_byte  : last received scancode
//   ps2_state : byte-valid level; each rising edge presents a new ps2_byte.
// Handshake: there is no back-pressure. The consumer takes ps2_byte on the
// clock where ps2_state is seen rising; the producer must hold ps2_byte
// stable from that rising edge until ps2_state has been low again.
interface game_ctrl_if;
  logic [7:0] ps2_byte;
  logic       ps2_state;

  modport master (output ps2_byte, output ps2_state);
  modport slave  (input  ps2_byte, input  ps2_state);
endinterface

// File: rtl/game_ctrl_ps2_key_decode.sv
// PS/2 scancode decoder.
// Ports:
//   clk_in, reset          : clock, async active-high reset
//   ps2_byte, ps2_state    : keyboard byte and its byte-valid level
//   left_held, right_held  : level flags, set on make, cleared on break
//   space_p, pause_p       : one-cycle pulses on make of space / P
// An 0xE0 prefix is transparent, so extended arrow codes (E0 6B / E0 74)
// behave like the plain codes. Unlisted codes are dropped, but still
// consume a pending break so the break never leaks onto a later byte.
module ps2_key_decode
  import game_pkg::*;
(
  input  logic       clk_in,
  input  logic       reset,
  input  logic [7:0] ps2_byte,
  input  logic       ps2_state,
  output logic       left_held,
  output logic       right_held,
  output logic       space_p,
  output logic       pause_p
);

  logic ps2_state_d;
  logic break_armed;
  logic new_byte;

  assign new_byte = ps2_state & ~ps2_state_d;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      ps2_state_d <= 1'b0;
      break_armed <= 1'b0;
      left_held   <= 1'b0;
      right_held  <= 1'b0;
      space_p     <= 1'b0;
      pause_p     <= 1'b0;
    end else begin
      ps2_state_d <= ps2_state;
      space_p     <= 1'b0;
      pause_p     <= 1'b0;
      if (new_byte) begin
        if (ps2_byte == SC_BREAK) begin
          break_armed <= 1'b1;
        end else if (ps2_byte != SC_EXT) begin
          if (break_armed) begin
            break_armed <= 1'b0;
            if (ps2_byte == SC_LEFT)  left_held  <= 1'b0;
            if (ps2_byte == SC_RIGHT) right_held <= 1'b0;
          end else begin
            case (ps2_byte)
              SC_LEFT:  left_held  <= 1'b1;
              SC_RIGHT: right_held <= 1'b1;
              SC_SPACE: space_p    <= 1'b1;
              SC_PAUSE: pause_p    <= 1'b1;
              default:  ;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Game controller: keyboard input, paddle position, game FSM, lives/score.
// Ports:
//   clk_in, reset             : 50 MHz clock, async active-high reset
//   bus (slave)               : ps2_byte / ps2_state keyboard bus
//   vs                        : VGA vsync (active-low, asynchronous)
//   level                     : 0 normal, 1 hard (ball speed, taken on SERVE entry)
//   ball_lost/brick_hit/bricks_clear : one-cycle events from the display datapath
//   paddle_x                  : paddle left edge in pixels
//   game_state                : FSM state (game_state_t encoding)
//   lives, score              : remaining lives, two-digit BCD score
//   ball_run, serve, ball_speed : ball motion enable, launch pulse, pixels/frame
module game_ctrl
  import game_pkg::*;
#(
  parameter int PADDLE_W     = 64,
  parameter int PADDLE_STEP  = 8,
  parameter int H_ACTIVE     = 640,
  parameter int LIVES_INIT   = 3,
  parameter int SERVE_FRAMES = 60
) (
  input  logic              clk_in,
  input  logic              reset,
  game_ctrl_if.slave        bus,
  input  logic              vs,
  input  logic              level,
  input  logic              ball_lost,
  input  logic              brick_hit,
  input  logic              bricks_clear,
  output logic [9:0]        paddle_x,
  output logic [2:0]        game_state,
  output logic [1:0]        lives,
  output logic [7:0]        score,
  output logic              ball_run,
  output logic              serve,
  output logic [2:0]        ball_speed
);

  localparam logic [9:0] PAD_MAX  = 10'(H_ACTIVE - PADDLE_W);
  localparam logic [9:0] PAD_MID  = 10'((H_ACTIVE - PADDLE_W) / 2);
  localparam logic [9:0] PAD_STEP = 10'(PADDLE_STEP);
  localparam int         FC_W     = $clog2(SERVE_FRAMES + 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(SERVE_FRAMES - 1);

  game_state_t     state, next_state;
  logic            left_held, right_held, space_p, pause_p;
  logic [2:0]      vs_sync;
  logic            frame_tick;
  logic [FC_W-1:0] frame_cnt;
  logic            start_game, enter_serve;

  ps2_key_decode u_keys (
    .clk_in     (clk_in),
    .reset      (reset),
    .ps2_byte   (bus.ps2_byte),
    .ps2_state  (bus.ps2_state),
    .left_held  (left_held),
    .right_held (right_held),
    .space_p    (space_p),
    .pause_p    (pause_p)
  );

  // vs_sync[1:0] is the two-flop synchroniser; vs_sync[2] is the previous
  // synchronised value for falling-edge detection.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) vs_sync <= 3'b000;
    else       vs_sync <= {vs_sync[1:0], vs};
  end
  assign frame_tick = vs_sync[2] & ~vs_sync[1];

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state  = state;
    serve       = 1'b0;
    ball_run    = 1'b0;
    start_game  = 1'b0;
    enter_serve = 1'b0;
    case (state)
      ST_IDLE: begin
        if (space_p) begin
          next_state  = ST_SERVE;
          start_game  = 1'b1;
          enter_serve = 1'b1;
        end
      end
      ST_SERVE: begin
        // Launch on the tick that brings the count to SERVE_FRAMES.
        if (space_p || (frame_tick && frame_cnt == FC_LAST)) begin
          next_state = ST_PLAY;
          serve      = 1'b1;
        end
      end
      ST_PLAY: begin
        ball_run = 1'b1;
        if (bricks_clear)   next_state = ST_WON;
        else if (ball_lost) next_state = ST_LOST;
        else if (pause_p)   next_state = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (pause_p) next_state = ST_PLAY;
      end
      ST_LOST: begin
        // lives is decremented this cycle; 1 means it is reaching 0.
        if (lives <= 2'd1) begin
          next_state = ST_OVER;
        end else begin
          next_state  = ST_SERVE;
          enter_serve = 1'b1;
        end
      end
      ST_WON, ST_OVER: begin
        if (space_p) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      paddle_x   <= PAD_MID;
      lives      <= 2'(LIVES_INIT);
      score      <= 8'h00;
      ball_speed <= 3'd2;
      frame_cnt  <= '0;
    end else begin
      if (start_game) begin
        lives    <= 2'(LIVES_INIT);
        score    <= 8'h00;
        paddle_x <= PAD_MID;
      end else if (frame_tick && (state == ST_SERVE || state == ST_PLAY)) begin
        if (left_held && !right_held) begin
          if (paddle_x <= PAD_STEP) paddle_x <= 10'd0;
          else                      paddle_x <= paddle_x - PAD_STEP;
        end else if (right_held && !left_held) begin
          if (paddle_x >= PAD_MAX - PAD_STEP) paddle_x <= PAD_MAX;
          else                                paddle_x <= paddle_x + PAD_STEP;
        end
      end

      if (state == ST_LOST) lives <= lives - 2'd1;

      if (enter_serve) begin
        frame_cnt  <= '0;
        ball_speed <= level ? 3'd4 : 3'd2;
      end else if (state == ST_SERVE && frame_tick) begin
        frame_cnt <= frame_cnt + 1'b1;
      end

      if (state == ST_PLAY && brick_hit) score <= bcd_inc_sat(score);
    end
  end

  assign game_state = state;

endmodule

// File: tb/tb_game_ctrl.sv
module tb_game_ctrl;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       vs, level, ball_lost, brick_hit, bricks_clear;
  logic [9:0] paddle_x;
  logic [2:0] game_state;
  logic [1:0] lives;
  logic [7:0] score;
  logic       ball_run, serve;
  logic [2:0] ball_speed;

  game_ctrl_if bus ();

  game_ctrl dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .bus          (bus),
    .vs           (vs),
    .level        (level),
    .ball_lost    (ball_lost),
    .brick_hit    (brick_hit),
    .bricks_clear (bricks_clear),
    .paddle_x     (paddle_x),
    .game_state   (game_state),
    .lives        (lives),
    .score        (score),
    .ball_run     (ball_run),
    .serve        (serve),
    .ball_speed   (ball_speed)
  );

  // clock / reset
  always #10 clk_in = ~clk_in;

  // behavioural game model (states as spec numbers, score as plain integer)
  int m_state, m_lives, m_score, m_paddle, m_frames, m_speed, m_serves;
  bit m_left, m_right;
  int serve_seen = 0;
  int n_checks = 0;
  int n_pass = 0;

  always @(negedge clk_in) if (serve === 1'b1) serve_seen++;

  function automatic int to_bcd(input int v);
    return ((v / 10) << 4) | (v % 10);
  endfunction

  task automatic m_reset();
    m_state = 0; m_lives = 3; m_score = 0; m_paddle = 288;
    m_frames = 0; m_speed = 2; m_left = 0; m_right = 0;
  endtask

  task automatic m_enter_serve();
    m_state = 1; m_frames = 0; m_speed = level ? 4 : 2;
  endtask

  task automatic m_space();
    case (m_state)
      0: begin m_lives = 3; m_score = 0; m_paddle = 288; m_enter_serve(); end
      1: begin m_state = 2; m_serves++; end
      5, 6: m_state = 0;
      default: ;
    endcase
  endtask

  task automatic m_frame();
    if (m_state == 1 || m_state == 2) begin
      if (m_left && !m_right)  m_paddle = (m_paddle < 8) ? 0 : m_paddle - 8;
      if (m_right && !m_left)  m_paddle = (m_paddle > 568) ? 576 : m_paddle + 8;
    end
    if (m_state == 1) begin
      m_frames++;
      if (m_frames == 60) begin m_state = 2; m_serves++; end
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.ps2_byte  = b;
    bus.ps2_state = 1'b1;
    tick(2);
    bus.ps2_state = 1'b0;
    tick(2);
  endtask

  task automatic press(input logic [7:0] code);
    send_byte(8'hE0);
    send_byte(code);
    if (code == 8'h6B) m_left = 1;
    if (code == 8'h74) m_right = 1;
  endtask

  task automatic release_key(input logic [7:0] code);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(code);
    if (code == 8'h6B) m_left = 0;
    if (code == 8'h74) m_right = 0;
  endtask

  task automatic tap(input logic [7:0] code);
    send_byte(code);
    if (code == 8'h29) m_space();
    if (code == 8'h4D) begin
      if (m_state == 2) m_state = 3;
      else if (m_state == 3) m_state = 2;
    end
    send_byte(8'hF0);
    send_byte(code);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      vs = 1'b0; tick(4);
      vs = 1'b1; tick(4);
      m_frame();
    end
  endtask

  task automatic pulse_ev(input bit lost, input bit hit, input bit clr);
    ball_lost = lost; brick_hit = hit; bricks_clear = clr;
    tick(1);
    ball_lost = 0; brick_hit = 0; bricks_clear = 0;
    tick(2);
    if (m_state == 2) begin
      if (clr) m_state = 5;
      else if (lost) begin
        m_lives--;
        if (m_lives == 0) m_state = 6;
        else m_enter_serve();
      end
      if (hit && m_score < 99) m_score++;
    end
  endtask

  // scoreboard
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"},      16'(game_state), 16'(m_state));
    chk({tag, ".lives"},      16'(lives),      16'(m_lives));
    chk({tag, ".score"},      16'(score),      16'(to_bcd(m_score)));
    chk({tag, ".paddle"},     16'(paddle_x),   16'(m_paddle));
    chk({tag, ".ball_run"},   16'(ball_run),   16'(m_state == 2));
    chk({tag, ".ball_speed"}, 16'(ball_speed), 16'(m_speed));
    chk({tag, ".serves"},     16'(serve_seen), 16'(m_serves));
  endtask

  initial begin
    int act, n;
    reset = 1'b1; vs = 1'b1; level = 1'b0;
    ball_lost = 0; brick_hit = 0; bricks_clear = 0;
    bus.ps2_byte = 8'h00; bus.ps2_state = 1'b0;
    m_serves = 0;
    m_reset();
    tick(3);
    check_all("reset");
    reset = 1'b0;
    tick(2);

    // start game
    tap(8'h29);
    check_all("start");

    // right held 50 frames in SERVE: saturates at 576
    press(8'h74);
    frames(50);
    check_all("right_sat");
    release_key(8'h74);
    frames(1);
    check_all("right_released");
    press(8'h6B);
    frames(3);
    release_key(8'h6B);
    level = 1'b1;   // not sampled until the next SERVE entry
    frames(5);
    check_all("serve_59");
    frames(1);
    check_all("auto_launch");

    // unlisted code and space are ignored in PLAY
    tap(8'h1C);
    tap(8'h29);
    check_all("play_ignore");

    // randomized play
    for (int i = 0; i < 20; i++) begin
      act = $urandom_range(0, 3);
      n = $urandom_range(1, 12);
      case (act)
        0: repeat (n % 6 + 1) pulse_ev(0, 1, 0);
        1: begin press(8'h6B); frames(n); release_key(8'h6B); end
        2: begin press(8'h74); frames(n); release_key(8'h74); end
        default: frames(n);
      endcase
      check_all($sformatf("rand%0d", i));
    end

    // lose all lives
    for (int i = 0; i < 3; i++) begin
      pulse_ev(1, 0, 0);
      check_all($sformatf("lost%0d", i));
      if (m_state == 1) begin
        tap(8'h29);
        check_all($sformatf("relaunch%0d", i));
      end
    end
    tap(8'h29);
    check_all("over_to_idle");

    // new game, pause behaviour, score saturation
    level = 1'($urandom_range(0, 1));
    tap(8'h29);
    check_all("game2_serve");
    tap(8'h29);
    repeat (5) pulse_ev(0, 1, 0);
    tap(8'h4D);
    check_all("paused");
    repeat (2) pulse_ev(0, 1, 0);
    press(8'h74);
    frames(2);
    release_key(8'h74);
    check_all("pause_frozen");
    tap(8'h4D);
    check_all("resumed");
    repeat (100) pulse_ev(0, 1, 0);
    check_all("score_sat");

    // simultaneous ball_lost and bricks_clear
    pulse_ev(1, 0, 1);
    check_all("won");
    tap(8'h29);
    check_all("won_to_idle");

    // reset during PLAY with a key held
    tap(8'h29);
    tap(8'h29);
    press(8'h74);
    frames(2);
    check_all("pre_reset");
    reset = 1'b1;
    #2;
    chk("async_reset.state", 16'(game_state), 16'd0);
    m_reset();
    tick(2);
    check_all("mid_reset");
    reset = 1'b0;
    tick(2);
    tap(8'h29);
    frames(1);
    check_all("post_reset_keys_cleared");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 SHALL have parameter PADDLE_W, default 64, paddle width in pixels.
REQ-002 SHALL have parameter PADDLE_STEP, default 8, paddle pixels moved per frame while a direction key is held.
REQ-003 SHALL have parameter H_ACTIVE, default 640, visible line width in pixels.
REQ-004 SHALL have parameter LIVES_INIT, default 3, lives at game start (1..3).
REQ-005 SHALL have parameter SERVE_FRAMES, default 60, frames held in SERVE before auto-launch.
REQ-006 SHALL have port clk_in, input, 1, 50 MHz system clock.
REQ-007 SHALL have port reset, input, 1, reset, asynchronous, active-high.
REQ-008 SHALL have port ps2_byte, input, 8, last received keyboard scancode.
REQ-009 SHALL have port ps2_state, input, 1, byte-valid level; a rising edge marks a new ps2_byte.
REQ-010 SHALL have port vs, input, 1, VGA vertical sync (active-low), asynchronous to clk_in.
REQ-011 SHALL have port level, input, 1, difficulty select (0 = normal, 1 = hard).
REQ-012 SHALL have ports ball_lost, brick_hit, bricks_clear, input, 1 each, single-cycle event pulses from the display datapath.
REQ-013 SHALL have port paddle_x, output, 10, left edge of paddle in pixels.
REQ-014 SHALL have port game_state, output, 3, current FSM state encoding.
REQ-015 SHALL have ports lives (output, 2) and score (output, 8, two BCD digits).
REQ-016 SHALL have ports ball_run (output, 1, ball motion enable), serve (output, 1, one-cycle launch pulse), ball_speed (output, 3, pixels/frame).

Function
REQ-017 SHALL synchronise vs through two flops; a synchronised falling edge SHALL produce frame_tick, one clk_in cycle wide.
REQ-018 SHALL decode ps2_byte on each ps2_state rising edge: 0xF0 arms a break flag; the next byte clears the matching held-key flag and disarms it; otherwise the byte sets the held flag.
REQ-019 SHALL track held flags for left (0x6B) and right (0x74), and emit one-cycle key pulses for space (0x29) and P (0x4D) on make only; 0xE0 prefix SHALL be ignored and unlisted codes discarded.
REQ-020 SHALL, on frame_tick in SERVE or PLAY, move paddle_x by -PADDLE_STEP (left only held) or +PADDLE_STEP (right only held); both or neither held SHALL not move it.
REQ-021 SHALL clamp paddle_x to 0..H_ACTIVE-PADDLE_W; no wrap-around.
REQ-022 SHALL implement states IDLE=0, SERVE=1, PLAY=2, PAUSE=3, LOST=4, WON=5, OVER=6.
REQ-023 IDLE: space -> SERVE, loading lives=LIVES_INIT, score=00, paddle_x centred ((H_ACTIVE-PADDLE_W)/2).
REQ-024 SERVE: frame counter counts frame_ticks; space or count reaching SERVE_FRAMES -> PLAY with serve pulsed in the same cycle as the transition.
REQ-025 PLAY: ball_run=1; P -> PAUSE; bricks_clear -> WON; ball_lost -> LOST; if both pulse same cycle, bricks_clear wins.
REQ-026 PAUSE: ball_run=0, paddle frozen; P -> PLAY; ps2 events other than P ignored.
REQ-027 LOST: decrement lives; lives reaching 0 -> OVER, else -> SERVE with frame counter cleared; occupies exactly one cycle.
REQ-028 WON and OVER: ball_run=0; space -> IDLE.
REQ-029 SHALL add 1 to score (BCD) on brick_hit in PLAY only; 99 SHALL saturate, not wrap.
REQ-030 SHALL drive ball_speed=2 when level=0 and 4 when level=1, sampled only on entry to SERVE.
REQ-031 ball_run SHALL be 1 only in PLAY; serve SHALL never be high outside the SERVE->PLAY transition cycle.

Reset
REQ-032 On reset: game_state=IDLE, paddle_x=(H_ACTIVE-PADDLE_W)/2, lives=LIVES_INIT, score=00, ball_run=0, serve=0, ball_speed=2, all key flags, break flag, sync flops and frame counter cleared.
REQ-033 Reset asserted mid-game SHALL abort any state immediately; no pending key pulse survives.

Structure
REQ-034 State encodings and scancode constants SHALL live in shared package game_pkg.
REQ-035 Scancode decode SHALL be sub-module ps2_key_decode (outputs: left_held, right_held, space_p, pause_p).

Verification
REQ-036 Reset, then bytes 0x29 -> state=1, lives=3, score=00, paddle_x=288.
REQ-037 Hold 0x74 for 50 frames in SERVE -> paddle_x saturates at 576; send F0,74 -> paddle stops.
REQ-038 In SERVE with no key, 60 frame_ticks -> serve pulses once, state=2, ball_run=1.
REQ-039 In PLAY, 3 ball_lost pulses (each followed by serve) -> lives 2,1,0, final state=6; space -> state=0.
REQ-040 In PLAY, 100 brick_hit pulses -> score=0x99; P -> state=3, brick_hit ignored; P -> state=2.
REQ-041 ball_lost and bricks_clear same cycle -> state=5, lives unchanged; reset during PLAY -> all REQ-032 values.
